// File: rtl/regbank_wb_if.sv
// ============================================================================
// Module   : regbank_wb_if
// Brief    : Read/write-back bus bundle between the CPU pipeline and regbank_wb
// Revision : 1.0
// ============================================================================
`default_nettype none

interface regbank_wb_if #(
  parameter int DWIDTH = 32,
  parameter int MWIDTH = 5,
  parameter int CWIDTH = 16
) ();

  logic              read_en;
  logic [MWIDTH-1:0] addr_1;
  logic [MWIDTH-1:0] addr_2;
  logic [DWIDTH-1:0] rd_data_1;
  logic [DWIDTH-1:0] rd_data_2;
  logic              rd_valid;
  logic              wb_valid;
  logic [DWIDTH-1:0] wb_instr;
  logic [DWIDTH-1:0] wb_result;
  logic              flag_zero;
  logic              flag_neg;
  logic [CWIDTH-1:0] wb_count;

  modport master (
    output read_en, addr_1, addr_2, wb_valid, wb_instr, wb_result,
    input  rd_data_1, rd_data_2, rd_valid, flag_zero, flag_neg, wb_count
  );

  modport slave (
    input  read_en, addr_1, addr_2, wb_valid, wb_instr, wb_result,
    output rd_data_1, rd_data_2, rd_valid, flag_zero, flag_neg, wb_count
  );

endinterface

`default_nettype wire

// File: rtl/regbank_wb.sv
// ============================================================================
// Module   : regbank_wb
// Brief    : Register bank with two registered read ports, write-back decode,
//            write-through bypass, CMP flags and a retired-write counter
// Revision : 1.0
// ============================================================================
`default_nettype none

module regbank_wb #(
  parameter int DWIDTH = 32,
  parameter int MWIDTH = 5,
  parameter int CWIDTH = 16
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  regbank_wb_if.slave    bus
);

  localparam int DEPTH = 2 ** MWIDTH;

  localparam logic [4:0] OP_LW  = 5'd0;
  localparam logic [4:0] OP_MOV = 5'd2;
  localparam logic [4:0] OP_ADD = 5'd3;
  localparam logic [4:0] OP_SUB = 5'd4;
  localparam logic [4:0] OP_MUL = 5'd5;
  localparam logic [4:0] OP_DIV = 5'd6;
  localparam logic [4:0] OP_AND = 5'd7;
  localparam logic [4:0] OP_OR  = 5'd8;
  localparam logic [4:0] OP_SHL = 5'd9;
  localparam logic [4:0] OP_SHR = 5'd10;
  localparam logic [4:0] OP_CMP = 5'd11;
  localparam logic [4:0] OP_NOT = 5'd12;

  logic [DWIDTH-1:0] regs [DEPTH];

  logic [4:0]        opcode;
  logic [MWIDTH-1:0] dest;
  logic              reg_we;
  logic              cmp_we;
  logic              bypass_1;
  logic              bypass_2;
  logic [DWIDTH-1:0] read_1;
  logic [DWIDTH-1:0] read_2;

  logic [DWIDTH-1:0] rd_data_1_q;
  logic [DWIDTH-1:0] rd_data_2_q;
  logic              rd_valid_q;
  logic              flag_zero_q;
  logic              flag_neg_q;
  logic [CWIDTH-1:0] wb_count_q;

  // Only the opcode and destination fields of the retiring instruction matter here
  logic unused_instr_bits;
  assign unused_instr_bits = ^bus.wb_instr[21:0];

  assign opcode = bus.wb_instr[31:27];
  assign dest   = bus.wb_instr[26:22];

  always_comb begin
    reg_we = 1'b0;
    cmp_we = 1'b0;
    if (bus.wb_valid) begin
      case (opcode)
        OP_LW, OP_MOV, OP_ADD, OP_SUB, OP_MUL, OP_DIV,
        OP_AND, OP_OR, OP_SHL, OP_SHR, OP_NOT: reg_we = 1'b1;
        OP_CMP:                                cmp_we = 1'b1;
        default: begin
          reg_we = 1'b0;
          cmp_we = 1'b0;
        end
      endcase
    end
  end

  // A same-cycle write to the addressed register wins over the stale array value
  assign bypass_1 = reg_we && (dest == bus.addr_1);
  assign bypass_2 = reg_we && (dest == bus.addr_2);
  assign read_1   = bypass_1 ? bus.wb_result : regs[bus.addr_1];
  assign read_2   = bypass_2 ? bus.wb_result : regs[bus.addr_2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (reg_we) begin
      regs[dest] <= bus.wb_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_1_q <= '0;
      rd_data_2_q <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      rd_valid_q <= bus.read_en;
      if (bus.read_en) begin
        rd_data_1_q <= read_1;
        rd_data_2_q <= read_2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_zero_q <= 1'b0;
      flag_neg_q  <= 1'b0;
      wb_count_q  <= '0;
    end else begin
      if (cmp_we) begin
        flag_zero_q <= (bus.wb_result == '0);
        flag_neg_q  <= bus.wb_result[DWIDTH-1];
      end
      if (reg_we) begin
        wb_count_q <= wb_count_q + 1'b1;
      end
    end
  end

  assign bus.rd_data_1 = rd_data_1_q;
  assign bus.rd_data_2 = rd_data_2_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.flag_zero = flag_zero_q;
  assign bus.flag_neg  = flag_neg_q;
  assign bus.wb_count  = wb_count_q;

endmodule

`default_nettype wire

// File: doc/regbank_wb.md
Name: regbank_wb

Overview:
- Register bank responder: serves the two read addresses and read enable produced by the decode-side read-address mux.
- Performs write-back of retiring instructions into the register array.
- Holds CMP result flags.
- Sits between decode (read side) and execute/write-back (write side) of the CPU.

Parameters:
DWIDTH, 32, data/instruction width
MWIDTH, 5, register address width; depth = 2**MWIDTH
CWIDTH, 16, width of retired-write counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
read_en  input  1  read request from decode stage
addr_1  input  MWIDTH  read address port 1
addr_2  input  MWIDTH  read address port 2
rd_data_1  output  DWIDTH  registered read data port 1
rd_data_2  output  DWIDTH  registered read data port 2
rd_valid  output  1  rd_data_1/2 updated by a read in the previous cycle
wb_valid  input  1  write-back instruction/result valid this cycle
wb_instr  input  DWIDTH  retiring instruction word
wb_result  input  DWIDTH  execute result for wb_instr
flag_zero  output  1  last CMP result was zero
flag_neg  output  1  last CMP result was negative (bit DWIDTH-1)
wb_count  output  CWIDTH  number of register writes performed, wraps

Behaviour:
- Clock is clk; reset is rst_n, asynchronous and active-low. Assertion clears immediately, mid-operation included:
  - all 2**MWIDTH registers = 0
  - rd_data_1 = rd_data_2 = 0, rd_valid = 0
  - flag_zero = flag_neg = 0, wb_count = 0
- No register is hardwired; register 0 is writable.
- Write-back decode:
  - opcode = wb_instr[31:27]; dest = wb_instr[26:22].
  - Register write when wb_valid=1 and opcode is one of: 0 LW, 2 MOV, 3 ADD, 4 SUB, 5 MUL, 6 DIV, 7 AND, 8 OR, 9 SHL, 10 SHR, 12 NOT.
  - On a register write: regs[dest] <= wb_result at the rising edge, and wb_count <= wb_count+1 (wraps to 0 after all-ones).
  - opcode 11 CMP with wb_valid=1: no register write, wb_count unchanged; flag_zero <= (wb_result==0), flag_neg <= wb_result[DWIDTH-1].
  - opcode 1 SW, opcodes 13..31, or wb_valid=0: no register write; flags and wb_count unchanged.
- Read path (1-cycle latency):
  - At a rising edge with read_en=1: rd_data_1 <= regs[addr_1], rd_data_2 <= regs[addr_2], rd_valid <= 1.
  - read_en=0: rd_data_1/2 hold their previous values; rd_valid <= 0.
- Write-through bypass:
  - Applies when a register write and a read occur in the same cycle and the read address equals dest.
  - The read port returns the new wb_result, not the stale register value.
  - Applies independently to each port; both ports may match.
- A write is visible to any read issued in a later cycle.
- addr_1 == addr_2 is legal; both ports return identical data.
- No back-pressure: every wb_valid is consumed in its cycle; every read_en is answered next cycle.

Test Plan:
- Reset: rst_n=0 asynchronously mid-clock after arbitrary writes -> all outputs 0 immediately; after release, read_en=1, addr_1=7, addr_2=31 -> next cycle rd_data_1=rd_data_2=0, rd_valid=1.
- Write-then-read:
  - Stimulus: wb_valid=1, wb_instr opcode 3 (ADD) dest=5, wb_result=0x1234_5678; next cycle read_en=1, addr_1=5.
  - Required: rd_data_1=0x1234_5678 one cycle after the read; wb_count=1.
- Bypass: same cycle as wb (opcode 2 MOV, dest=9, result 0xDEAD_BEEF), read_en=1, addr_1=9, addr_2=9 -> next cycle both ports = 0xDEAD_BEEF.
- Non-writing ops:
  - wb opcode 1 (SW) dest=4, result=0xFFFF_FFFF -> regs[4] stays 0, wb_count unchanged.
  - wb opcode 11 (CMP) with result 0x8000_0000 -> flag_neg=1, flag_zero=0.
  - Then CMP with result 0 -> flag_zero=1, flag_neg=0.
- Read hold: read_en=1 then read_en=0 for 3 cycles while regs change -> rd_data holds the first read's values, rd_valid=1 then 0.
- Counter wrap: CWIDTH=4, 17 consecutive writing ops -> wb_count sequence reaches 15, then 0, then 1.
